// File: rtl/rr_grant_ctrl8.sv
// Round-robin owner select for 8 requesters with hold-limit preemption and a turnaround gap.
// Latency: grant registered one cycle after req is sampled in IDLE; no backpressure, owner held until release/timeout.
module rr_grant_ctrl8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       preempt
);

    localparam int unsigned     HW       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LIM = HW'(MAX_HOLD);
    localparam logic            TMO_EN   = (MAX_HOLD != 0);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_ptr, w_ptr_nxt;
    logic [HW-1:0]   r_hold_cnt, w_hold_nxt;
    logic [7:0]      r_grant, w_grant_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic            r_vld, w_vld_nxt;
    logic            r_pre, w_pre_nxt;

    logic            w_found;
    logic [2:0]      w_pick;
    logic [2:0]      w_cand;
    logic            w_vol_rel;
    logic            w_tmo_rel;

    // First set request scanning upward from r_ptr, wrapping 7 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        w_cand  = r_ptr;
        for (int k = 0; k < 8; k++) begin
            w_cand = r_ptr + 3'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_vol_rel = ~req[r_idx];
    assign w_tmo_rel = TMO_EN && (r_hold_cnt == HOLD_LIM);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_vld_nxt   = r_vld;
        w_pre_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = 8'h01 << w_pick;
                    w_idx_nxt   = w_pick;
                    w_vld_nxt   = 1'b1;
                    w_hold_nxt  = HW'(1);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_vol_rel || w_tmo_rel) begin
                    w_grant_nxt = 8'h00;
                    w_idx_nxt   = 3'd0;
                    w_vld_nxt   = 1'b0;
                    w_ptr_nxt   = r_idx + 3'd1;
                    // A release coinciding with the timeout counts as voluntary.
                    w_pre_nxt   = ~w_vol_rel;
                    w_state_nxt = GAP;
                end else if (TMO_EN && (r_hold_cnt != HOLD_LIM)) begin
                    w_hold_nxt = r_hold_cnt + HW'(1);
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_grant_nxt = 8'h00;
                w_idx_nxt   = 3'd0;
                w_vld_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 3'd0;
            r_hold_cnt <= '0;
            r_grant    <= 8'h00;
            r_idx      <= 3'd0;
            r_vld      <= 1'b0;
            r_pre      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_grant    <= w_grant_nxt;
            r_idx      <= w_idx_nxt;
            r_vld      <= w_vld_nxt;
            r_pre      <= w_pre_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = r_vld;
    assign preempt     = r_pre;

endmodule

// File: tb/tb_rr_grant_ctrl8.sv
// Directed bench for rr_grant_ctrl8: reset, single owner, round robin, timeout, release/timeout tie, reset mid-grant.
module tb_rr_grant_ctrl8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_grant_ctrl8 #(.MAX_HOLD(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic [7:0] g, input logic [2:0] ix,
                           input logic v, input logic p);
        check({tag, ".grant"},   32'(grant),       32'(g));
        check({tag, ".idx"},     32'(grant_idx),   32'(ix));
        check({tag, ".valid"},   32'(grant_valid), 32'(v));
        check({tag, ".preempt"}, 32'(preempt),     32'(p));
    endtask

    // Inputs change on the falling edge; outputs are observed on the next falling edge.
    task automatic step(input logic [7:0] r);
        req = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(8'h00);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] oh;
        logic [2:0] e;
        rst = 1'b1;
        req = 8'h00;
        @(negedge clk);
        step(8'h00);
        rst = 1'b0;
        exp_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step(8'h00);
            exp_out("idle", 8'h00, 3'd0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 5; i++) begin
            step(8'h08);
            exp_out("single", 8'h08, 3'd3, 1'b1, 1'b0);
        end
        step(8'h00);
        exp_out("single_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        step(8'h00);
        exp_out("single_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        step(8'hFF);
        exp_out("single_ptr4", 8'h10, 3'd4, 1'b1, 1'b0);

        do_reset();
        exp_out("rst_rr", 8'h00, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            e  = 3'(k % 8);
            oh = 8'h01 << e;
            step(8'hFF);
            exp_out("rr_own1", oh, e, 1'b1, 1'b0);
            step(8'hFF);
            exp_out("rr_own2", oh, e, 1'b1, 1'b0);
            step(8'hFF & ~oh);
            exp_out("rr_rel", 8'h00, 3'd0, 1'b0, 1'b0);
            step(8'hFF);
            exp_out("rr_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        end

        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(8'h21);
            exp_out("to_idx0", 8'h01, 3'd0, 1'b1, 1'b0);
        end
        step(8'h21);
        exp_out("to_pre0", 8'h00, 3'd0, 1'b0, 1'b1);
        step(8'h21);
        exp_out("to_gap0", 8'h00, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(8'h21);
            exp_out("to_idx5", 8'h20, 3'd5, 1'b1, 1'b0);
        end
        step(8'h21);
        exp_out("to_pre5", 8'h00, 3'd0, 1'b0, 1'b1);
        step(8'h21);
        exp_out("to_gap5", 8'h00, 3'd0, 1'b0, 1'b0);
        step(8'h21);
        exp_out("to_idx0_again", 8'h01, 3'd0, 1'b1, 1'b0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(8'h04);
            exp_out("tie_idx2", 8'h04, 3'd2, 1'b1, 1'b0);
        end
        step(8'h00);
        exp_out("tie_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        step(8'h00);
        exp_out("tie_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        step(8'h09);
        exp_out("tie_ptr3", 8'h08, 3'd3, 1'b1, 1'b0);

        do_reset();
        step(8'h02);
        exp_out("mid_idx1", 8'h02, 3'd1, 1'b1, 1'b0);
        step(8'h00);
        step(8'h00);
        step(8'h40);
        exp_out("mid_idx6", 8'h40, 3'd6, 1'b1, 1'b0);
        step(8'h40);
        exp_out("mid_idx6_hold", 8'h40, 3'd6, 1'b1, 1'b0);
        rst = 1'b1;
        step(8'h40);
        exp_out("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(8'h41);
        exp_out("post_rst_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
